// File: rtl/squeeze_ker_wr_sched.sv
// Write-side scheduler for the squeeze kernel RAM: circular-buffer writes,
// completed-layer counting and occupancy-based back-pressure.
module squeeze_ker_wr_sched #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] layer_words_i,
    input  logic [6:0]        total_layers_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [DATA_W-1:0] ram_wr_data_o,
    input  logic              rd_layer_done_i,
    output logic [6:0]        squeeze_layer_ready_no_o,
    output logic              load_done_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] layer_words;
    logic [ADDR_W:0]   occ;
    logic [6:0]        total_layers;
    logic [6:0]        ready_no;
    logic              err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              accept;
    logic              last_word;
    logic              underflow;
    logic [ADDR_W:0]   layer_size;
    logic [ADDR_W:0]   occ_inc;
    logic [ADDR_W:0]   occ_next;
    logic [6:0]        ready_no_inc;

    // Ready depends on registers only, never on ld_valid_i.
    assign ld_ready_o = (state == LOAD) && (occ < DEPTH_W);
    assign accept     = ld_valid_i && ld_ready_o;
    assign last_word  = accept && (wcnt == layer_words);

    always_comb begin
        layer_size   = {1'b0, layer_words} + 1'b1;
        occ_inc      = occ + {{ADDR_W{1'b0}}, accept};
        underflow    = rd_layer_done_i && (occ_inc < layer_size);
        occ_next     = occ_inc;
        if (rd_layer_done_i) begin
            occ_next = underflow ? '0 : occ_inc - layer_size;
        end
        ready_no_inc = (ready_no == 7'd127) ? ready_no : ready_no + 7'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wptr         <= '0;
            wcnt         <= '0;
            layer_words  <= '0;
            occ          <= '0;
            total_layers <= '0;
            ready_no     <= '0;
            err          <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else if (start_i) begin
            layer_words  <= layer_words_i;
            total_layers <= total_layers_i;
            wptr         <= '0;
            wcnt         <= '0;
            occ          <= '0;
            ready_no     <= '0;
            err          <= 1'b0;
            wr_en        <= 1'b0;
            state        <= (total_layers_i == 7'd0) ? DONE : LOAD;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= wptr;
                wr_data <= ld_data_i;
                wptr    <= wptr + 1'b1;
                wcnt    <= last_word ? '0 : wcnt + 1'b1;
            end
            // Count advances on the same edge that issues the last word's write.
            if (last_word) begin
                ready_no <= ready_no_inc;
            end
            occ <= occ_next;
            if (underflow) begin
                err <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (last_word && (ready_no_inc == total_layers)) begin
                        state <= DONE;
                    end else if (accept && !rd_layer_done_i && (occ_inc == DEPTH_W)) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (rd_layer_done_i) begin
                        state <= LOAD;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    assign ram_wr_en_o              = wr_en;
    assign ram_wr_addr_o            = wr_addr;
    assign ram_wr_data_o            = wr_data;
    assign squeeze_layer_ready_no_o = ready_no;
    assign load_done_o              = (state == DONE);
    assign err_o                    = err;

endmodule

// File: doc/squeeze_ker_wr_sched.md
Name: squeeze_ker_wr_sched

Overview:
- Write-side scheduler for the squeeze kernel RAM.
- Accepts a stream of kernel words from the kernel loader and writes them into the RAM as a circular buffer.
- Counts completed kernel layers and publishes that count to the read controller as squeeze_layer_ready_no.
- Applies back-pressure when unread data would be overwritten; the read side frees space with a per-layer done pulse.

Parameters:
- DATA_W, 64, kernel word width.
- ADDR_W, 11, RAM address width.
- DEPTH, 2048, RAM words; must equal 2**ADDR_W.

Ports:
- clk_i  in  1  clock; the block uses this single clock only.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse; starts a new kernel load.
- layer_words_i  in  ADDR_W  words per layer minus 1; sampled on start_i.
- total_layers_i  in  7  number of layers to load; sampled on start_i.
- ld_valid_i  in  1  loader word valid.
- ld_data_i  in  DATA_W  loader word.
- ld_ready_o  out  1  block accepts a word on ld_valid_i && ld_ready_o.
- ram_wr_en_o  out  1  RAM write strobe.
- ram_wr_addr_o  out  ADDR_W  RAM write address.
- ram_wr_data_o  out  DATA_W  RAM write data.
- rd_layer_done_i  in  1  one pulse per layer consumed by the read controller.
- squeeze_layer_ready_no_o  out  7  layers fully written since start.
- load_done_o  out  1  all total_layers written.
- err_o  out  1  sticky: a done pulse arrived with insufficient occupancy.

Behaviour:
- Reset (rst_i=1 at clk edge) sets:
  - state=IDLE.
  - All counters 0, including occupancy (occ) and the write pointer (wptr).
  - ld_ready_o=0, ram_wr_en_o=0, ram_wr_addr_o=0, ram_wr_data_o=0.
  - squeeze_layer_ready_no_o=0, load_done_o=0, err_o=0.
- start_i (any state, including mid-load), lower priority than rst_i:
  - Latches layer_words_i and total_layers_i.
  - Clears wptr, occ, the in-layer word counter (wcnt), squeeze_layer_ready_no_o, load_done_o and err_o.
  - Next state is LOAD, or DONE if total_layers_i==0.
  - A handshake or rd_layer_done_i in the start cycle is ignored.
- States:
  - IDLE: ld_ready_o=0; waits for start_i.
  - LOAD: ld_ready_o = (occ < DEPTH); combinational from registers only, with no path from ld_valid_i.
  - FULL: entered from LOAD when an accept makes occ==DEPTH (with no simultaneous free); ld_ready_o=0; returns to LOAD on the cycle after rd_layer_done_i reduces occ.
  - DONE: ld_ready_o=0, load_done_o=1; rd_layer_done_i still decrements occ; exits only via start_i or rst_i.
- Accept (ld_valid_i && ld_ready_o) produces on the next cycle:
  - ram_wr_en_o=1, ram_wr_addr_o=wptr, ram_wr_data_o=ld_data_i (latency 1).
  - wptr increments and wraps from DEPTH-1 to 0.
  - ram_wr_en_o is low in all cycles without an accept.
- Layer counting:
  - wcnt increments per accept.
  - When wcnt==layer_words, wcnt returns to 0 and squeeze_layer_ready_no_o increments in the same edge as the last word's RAM write is issued, so the count is valid no earlier than the data.
  - If the incremented count == total_layers, the next state is DONE.
- Occupancy, per cycle: occ_next = occ + accept - (rd_layer_done_i ? layer_words+1 : 0).
  - Width ADDR_W+1.
  - A simultaneous accept and free is applied in one cycle.
- Underflow: rd_layer_done_i with occ + accept < layer_words+1 sets err_o (sticky) and sets occ to 0.
- squeeze_layer_ready_no_o is monotonic between starts and saturates at 127.
- ld_data_i and ld_valid_i are don't-care when ld_ready_o=0.

Test Plan:
- Basic load:
  - Stimulus: rst_i; start_i with layer_words=3, total_layers=2; continuous ld_valid_i with data 0..7.
  - Response: writes at addr 0..7, each one cycle after its accept.
  - Response: ready_no becomes 1 with the addr-3 write and 2 with the addr-7 write.
  - Response: load_done_o=1 next cycle; ld_ready_o=0 thereafter.
- Full back-pressure:
  - Stimulus: layer_words=1023, total_layers=4, no rd_layer_done_i.
  - Response: after 2048 accepts ld_ready_o=0 (FULL) and ready_no=2.
  - Stimulus: one rd_layer_done_i.
  - Response: occ=1024, ld_ready_o=1 next cycle, next write at addr 0 (wrap).
- Simultaneous events:
  - Stimulus: with occ=2047 in LOAD, an accept and rd_layer_done_i in the same cycle.
  - Response: occ=1024; stays in LOAD with no FULL entry.
- Underflow:
  - Stimulus: layer_words=7; after 3 accepts, a rd_layer_done_i pulse.
  - Response: err_o=1 and occ=0.
  - Stimulus: a following start_i.
  - Response: err_o clears.
- Restart mid-load:
  - Stimulus: start_i after 5 of 16 words.
  - Response: ready_no=0, next write at addr 0, wcnt restarted; ld_valid_i in the start cycle produces no write.
- Zero-layer and reset precedence:
  - Stimulus: start_i with total_layers=0.
  - Response: load_done_o=1 next cycle and no writes.
  - Stimulus: rst_i and start_i asserted together.
  - Response: block ends in IDLE with all outputs 0.
